acs_viterbi_param: RTL and testbench
====================================

ACS_VITERBI_PARAM -- requirements
Module: acs_viterbi_param

Interface
REQ-001 Parameter K, default 3, meaning constraint length (legal 3..7); NS = 2^(K-1) trellis states, SW = K-1 state bits.
REQ-002 Parameter G0, default 7 (octal 7, binary 111), meaning generator polynomial for code bit c0, K bits.
REQ-003 Parameter G1, default 5 (octal 5, binary 101), meaning generator polynomial for code bit c1, K bits.
REQ-004 Parameter BMW, default 2, meaning branch-metric width.
REQ-005 Parameter PMW, default 8, meaning path-metric width; PMW > BMW+K is required.
REQ-006 clk input 1: clock; all state updates on the rising edge.
REQ-007 rst input 1: reset, asynchronous, active-low.
REQ-008 i_start input 1: single-cycle pulse that reinitialises the path metrics.
REQ-009 i_valid input 1: the branch metrics on i_bm are valid this cycle and one trellis step is performed.
REQ-010 i_bm input 4*BMW: unsigned branch metrics; slice c (c = 2*c0 + c1) occupies bits [c*BMW +: BMW].
REQ-011 o_valid output 1: step result valid, a registered one-cycle pulse.
REQ-012 o_dec output NS: survivor decision bits; bit ns = LSB of the chosen predecessor of state ns.
REQ-013 o_best_state output SW: index of the minimum-metric state after the step.
REQ-014 o_norm output PMW: normalisation amount subtracted in this step, equal to the pre-normalisation minimum.
REQ-015 o_step output 16: steps since the last start/reset; saturates at 16'hFFFF.

Function
REQ-016 Trellis: from state s with input bit b, the next state SHALL be {b, s[SW-1:1]}; ns has predecessors p0 = {ns[SW-2:0],0} and p1 = {ns[SW-2:0],1}, with b = ns[SW-1].
REQ-017 Transition codeword: r = {b, s} (K bits); c0 = XOR-reduce(r & G0); c1 = XOR-reduce(r & G1); the branch metric is slice 2*c0+c1 of i_bm.
REQ-018 Candidates: cand_j = pm[pj] + bm(pj→ns), computed at PMW+1 bits and clamped to PMAX = 2^PMW - 1.
REQ-019 Select: sel[ns] = min(cand0, cand1); on a tie, p0 wins; o_dec[ns] = 0 if p0 is chosen, else 1.
REQ-020 Normalise: m = min over all sel; new pm[ns] = sel[ns] - m, except sel[ns] == PMAX, which stays PMAX (saturated metrics are never reduced).
REQ-021 Best state: the lowest index ns with sel[ns] == m; registered into o_best_state; m is registered into o_norm.
REQ-022 Latency 1 cycle: i_valid high at edge t updates pm, o_dec, o_best_state and o_norm, and pulses o_valid at edge t.
REQ-023 When i_valid is low: pm, o_dec, o_best_state, o_norm and o_step hold their values; o_valid = 0.
REQ-024 i_start alone: pm[0] = 0, pm[others] = PMAX, o_step = 0, o_valid = 0; o_dec, o_best_state and o_norm cleared to 0.
REQ-025 i_start together with i_valid: the step is computed from the initial metrics of REQ-024, and o_step = 1.
REQ-026 o_step increments on each valid step, saturating at 16'hFFFF with no wrap.
REQ-027 All comparisons are unsigned; no metric ever exceeds PMAX or goes negative.

Reset
REQ-028 rst low, asynchronously and at any time including mid-step: pm set per REQ-024; o_valid, o_dec, o_best_state, o_norm and o_step = 0.
REQ-029 After rst is released, the first valid step SHALL behave exactly as the first step after i_start.

Verification (K=3, G0=7, G1=5, BMW=2, PMW=8)
REQ-030 Reset, then i_start, then one i_valid with i_bm = {bm11=2, bm10=2, bm01=2, bm00=0} → pm = [0,255,2,255], o_dec = 0000, o_best_state = 0, o_norm = 0, o_valid pulses once.
REQ-031 Repeat that i_bm for a second step → pm = [0,4,2,4], o_dec = 0000, o_best_state = 0, o_step = 2.
REQ-032 All-ones i_bm for 10 steps after start → o_norm > 0 on the steady-state steps, every pm ≤ PMAX, and min pm = 0 after each step.
REQ-033 Equal candidates (all bm = 0, all pm = 0) → o_dec = 0000 and o_best_state = 0 (tie rules hold).
REQ-034 Assert rst in the same cycle as i_valid after 5 steps → outputs 0 immediately; the next step matches REQ-030.
REQ-035 i_start with i_valid in the same cycle after 3 steps → result equals REQ-030, o_step = 1; also check the 65535-step o_step saturation.

Source files
------------

// File: rtl/acs_viterbi_param_if.sv
// Step request/response bundle for the Viterbi add-compare-select unit.
// The master drives the start pulse and branch metrics; the slave returns
// one registered result per trellis step.
interface acs_viterbi_param_if #(
  parameter int unsigned K   = 3,
  parameter int unsigned BMW = 2,
  parameter int unsigned PMW = 8
);
  localparam int unsigned NS = 1 << (K - 1);
  localparam int unsigned SW = K - 1;

  logic               i_start;
  logic               i_valid;
  logic [4*BMW-1:0]   i_bm;
  logic               o_valid;
  logic [NS-1:0]      o_dec;
  logic [SW-1:0]      o_best_state;
  logic [PMW-1:0]     o_norm;
  logic [15:0]        o_step;

  modport master (
    output i_start, i_valid, i_bm,
    input  o_valid, o_dec, o_best_state, o_norm, o_step
  );

  modport slave (
    input  i_start, i_valid, i_bm,
    output o_valid, o_dec, o_best_state, o_norm, o_step
  );
endinterface

// File: rtl/acs_viterbi_param.sv
// Parameterised Viterbi add-compare-select stage.
// Each valid step extends every trellis state from its two predecessors,
// keeps the smaller candidate (p0 on ties), normalises all metrics by the
// step minimum and reports decisions, best state and the amount removed.
module acs_viterbi_param #(
  parameter int unsigned K   = 3,
  parameter int unsigned G0  = 7,
  parameter int unsigned G1  = 5,
  parameter int unsigned BMW = 2,
  parameter int unsigned PMW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  acs_viterbi_param_if.slave     bus
);

  localparam int unsigned NS = 1 << (K - 1);
  localparam int unsigned SW = K - 1;
  localparam logic [PMW-1:0] PMAX = '1;
  localparam logic [K-1:0]   G0M  = K'(G0);
  localparam logic [K-1:0]   G1M  = K'(G1);

  logic [PMW-1:0] pm      [NS];
  logic [PMW-1:0] pm_src  [NS];
  logic [PMW-1:0] cand0   [NS];
  logic [PMW-1:0] cand1   [NS];
  logic [PMW-1:0] sel     [NS];
  logic [PMW-1:0] pm_next [NS];
  logic [NS-1:0]  dec_next;
  logic [PMW-1:0] min_val;
  logic [SW-1:0]  best_next;
  logic [15:0]    step_base;
  logic [15:0]    step_next;

  logic           valid_q;
  logic [NS-1:0]  dec_q;
  logic [SW-1:0]  best_q;
  logic [PMW-1:0] norm_q;
  logic [15:0]    step_q;

  // Codeword index 2*c0+c1 for the transition register r = {b, s}.
  function automatic logic [1:0] code_idx(input logic [K-1:0] r);
    return {^(r & G0M), ^(r & G1M)};
  endfunction

  // Branch metric of transition r taken from the packed metric vector.
  function automatic logic [BMW-1:0] branch(input logic [4*BMW-1:0] bm,
                                            input logic [K-1:0]     r);
    logic [1:0] c;
    c = code_idx(r);
    return bm[c * BMW +: BMW];
  endfunction

  // Metric plus branch at PMW+1 bits, clamped to PMAX.
  function automatic logic [PMW-1:0] add_sat(input logic [PMW-1:0] a,
                                             input logic [BMW-1:0] b);
    logic [PMW:0] s;
    s = {1'b0, a} + {{(PMW + 1 - BMW){1'b0}}, b};
    return s[PMW] ? PMAX : s[PMW-1:0];
  endfunction

  // A start pulse substitutes the initial metrics so start+valid steps from them.
  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      if (bus.i_start) begin
        pm_src[s] = (s == 0) ? '0 : PMAX;
      end else begin
        pm_src[s] = pm[s];
      end
    end
  end

  // Add: both candidate metrics for every next state.
  always_comb begin
    logic [SW-1:0] nsv;
    logic [SW-1:0] p0;
    logic [SW-1:0] p1;
    nsv = '0;
    p0  = '0;
    p1  = '0;
    for (int unsigned ns = 0; ns < NS; ns++) begin
      nsv       = SW'(ns);
      p0        = {nsv[SW-2:0], 1'b0};
      p1        = {nsv[SW-2:0], 1'b1};
      cand0[ns] = add_sat(pm_src[p0], branch(bus.i_bm, {nsv[SW-1], p0}));
      cand1[ns] = add_sat(pm_src[p1], branch(bus.i_bm, {nsv[SW-1], p1}));
    end
  end

  // Compare-select: p1 only wins when strictly smaller.
  always_comb begin
    dec_next = '0;
    for (int unsigned ns = 0; ns < NS; ns++) begin
      if (cand1[ns] < cand0[ns]) begin
        sel[ns]      = cand1[ns];
        dec_next[ns] = 1'b1;
      end else begin
        sel[ns]      = cand0[ns];
      end
    end
  end

  // Minimum selected metric and the lowest state index holding it.
  always_comb begin
    min_val   = sel[0];
    best_next = '0;
    for (int unsigned i = 1; i < NS; i++) begin
      if (sel[i] < min_val) begin
        min_val   = sel[i];
        best_next = SW'(i);
      end
    end
  end

  // Normalise; saturated metrics stay pinned at PMAX.
  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      if (sel[i] == PMAX) begin
        pm_next[i] = PMAX;
      end else begin
        pm_next[i] = sel[i] - min_val;
      end
    end
  end

  // Step counter restarts on start and saturates at all-ones.
  always_comb begin
    step_base = bus.i_start ? '0 : step_q;
    step_next = (&step_base) ? step_base : step_base + 16'd1;
  end

  // Metric and result registers; asynchronous reset gives the start state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NS; i++) begin
        pm[i] <= (i == 0) ? '0 : PMAX;
      end
      valid_q <= 1'b0;
      dec_q   <= '0;
      best_q  <= '0;
      norm_q  <= '0;
      step_q  <= '0;
    end else if (bus.i_valid) begin
      for (int unsigned i = 0; i < NS; i++) begin
        pm[i] <= pm_next[i];
      end
      valid_q <= 1'b1;
      dec_q   <= dec_next;
      best_q  <= best_next;
      norm_q  <= min_val;
      step_q  <= step_next;
    end else if (bus.i_start) begin
      for (int unsigned i = 0; i < NS; i++) begin
        pm[i] <= (i == 0) ? '0 : PMAX;
      end
      valid_q <= 1'b0;
      dec_q   <= '0;
      best_q  <= '0;
      norm_q  <= '0;
      step_q  <= '0;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_dec        = dec_q;
  assign bus.o_best_state = best_q;
  assign bus.o_norm       = norm_q;
  assign bus.o_step       = step_q;

endmodule

// File: tb/tb_acs_viterbi_param.sv
// Scoreboard bench for acs_viterbi_param (K=3, G0=7, G1=5, BMW=2, PMW=8).
module tb_acs_viterbi_param;

  localparam int unsigned K    = 3;
  localparam int unsigned G0   = 7;
  localparam int unsigned G1   = 5;
  localparam int unsigned BMW  = 2;
  localparam int unsigned PMW  = 8;
  localparam int unsigned NS   = 4;
  localparam int unsigned SW   = 2;
  localparam int unsigned PMAX = 255;
  localparam logic [7:0]  BM_A = {2'd2, 2'd2, 2'd2, 2'd0};

  typedef struct {
    int unsigned dec;
    int unsigned best;
    int unsigned norm;
    int unsigned step;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acs_viterbi_param_if #(.K(K), .BMW(BMW), .PMW(PMW)) bus ();

  acs_viterbi_param #(.K(K), .G0(G0), .G1(G1), .BMW(BMW), .PMW(PMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned pm_m[NS];
  int unsigned step_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int unsigned parity(input int unsigned x);
    int unsigned p = 0;
    for (int i = 0; i < 32; i++) p ^= (x >> i) & 1;
    return p;
  endfunction

  task automatic model_init();
    for (int s = 0; s < NS; s++) pm_m[s] = (s == 0) ? 0 : PMAX;
    step_m = 0;
  endtask

  // Reference trellis step from the code definition using plain integers.
  task automatic model_step(input logic [7:0] bm, output exp_t e);
    int unsigned sel[NS];
    int unsigned m;
    e.dec  = 0;
    e.best = 0;
    for (int ns = 0; ns < NS; ns++) begin
      int unsigned b;
      b = ns >> (SW - 1);
      for (int j = 0; j < 2; j++) begin
        int unsigned p, r, c, bmv, cand;
        p    = ((ns << 1) % NS) + j;
        r    = (b << SW) + p;
        c    = 2 * parity(r & G0) + parity(r & G1);
        bmv  = (int'(bm) >> (c * BMW)) % 4;
        cand = pm_m[p] + bmv;
        if (cand > PMAX) cand = PMAX;
        if (j == 0) sel[ns] = cand;
        else if (cand < sel[ns]) begin
          sel[ns] = cand;
          e.dec  += (1 << ns);
        end
      end
    end
    m = PMAX + 1;
    for (int ns = NS - 1; ns >= 0; ns--) if (sel[ns] <= m) begin m = sel[ns]; e.best = ns; end
    for (int ns = 0; ns < NS; ns++) pm_m[ns] = (sel[ns] == PMAX) ? PMAX : sel[ns] - m;
    if (step_m < 65535) step_m++;
    e.norm = m;
    e.step = step_m;
  endtask

  // Drive one cycle of inputs at the falling edge; expected result is queued.
  task automatic drive(input logic start, input logic valid, input logic [7:0] bm);
    exp_t e;
    @(negedge clk);
    bus.i_start = start;
    bus.i_valid = valid;
    bus.i_bm    = bm;
    if (start) model_init();
    if (valid) begin
      model_step(bm, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_dec"},   32'(bus.o_dec), 0);
    chk({tag, "_best"},  32'(bus.o_best_state), 0);
    chk({tag, "_norm"},  32'(bus.o_norm), 0);
    chk({tag, "_step"},  32'(bus.o_step), 0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("dec",  32'(bus.o_dec), e.dec);
          chk("best", 32'(bus.o_best_state), e.best);
          chk("norm", 32'(bus.o_norm), e.norm);
          chk("step", 32'(bus.o_step), e.step);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_bm    = '0;
    rst         = 1'b0;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b1;

    // Start alone, then the two directed steps.
    drive(1'b1, 1'b0, '0);
    chk_cleared("start_only");
    drive(1'b0, 1'b1, BM_A);
    drive(1'b0, 1'b1, BM_A);
    idle(3);
    chk("hold_step", 32'(bus.o_step), 2);
    chk("pulse_once", 32'(bus.o_valid), 0);

    // All-ones metrics: constant normalisation every step.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'hFF);
    chk("ones_norm_nonzero", 32'(bus.o_norm != 0), 1);

    // Zero metrics drive all states to equal metrics; ties must pick p0 / state 0.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, '0);
    chk("tie_dec", 32'(bus.o_dec), 0);
    chk("tie_best", 32'(bus.o_best_state), 0);

    // Random steps with occasional restarts.
    for (int i = 0; i < 200; i++)
      drive(1'(($urandom_range(0, 9) == 0)), 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
    idle(2);

    // Asynchronous reset landing in a valid cycle.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_bm    = 8'($urandom_range(0, 255));
    #2;
    rst = 1'b0;
    #1;
    chk_cleared("async_rst");
    @(posedge clk);
    #1;
    chk_cleared("rst_edge");
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    model_init();
    drive(1'b0, 1'b1, BM_A);

    // Start together with valid after some history.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    drive(1'b1, 1'b1, BM_A);
    drive(1'b0, 1'b1, BM_A);

    // Step counter saturation.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 65537; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    chk("step_saturated", 32'(bus.o_step), 65535);

    idle(3);
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
